shim_spi_cfg_apply_ctrl: RTL
============================

# shim_spi_cfg_apply_ctrl

Sequences safe application of shim configuration to the SPI-domain core. Takes already-synchronized config values (threshold, integration window, enables) plus an aggregate stability flag. Waits for a change to settle, then requests the running SPI core to drain to a safe point before committing the new set atomically. Sits between the config synchronizer outputs and the SPI/integrator datapath.

## Interface
- SETTLE_CYCLES, 4: consecutive stable, matching samples required before commit (min 2)
- DRAIN_TIMEOUT, 1024: cycles allowed in DRAIN before fault (min 1)

- spi_clk  in  1  SPI-domain clock
- sync_reset  in  1  synchronous, active-high reset
- integ_thresh_avg_in  in  15  synchronized threshold candidate
- integ_window_in  in  32  synchronized window candidate
- integ_en_in  in  1  synchronized integrator enable candidate
- spi_en_in  in  1  synchronized SPI enable candidate
- in_stable  in  1  all upstream synchronizers report stable
- drain_ack  in  1  core is at a safe point, held while drained
- err_clear  in  1  clears ERROR state (level, sampled)
- integ_thresh_avg_out  out  15  committed threshold
- integ_window_out  out  32  committed window
- integ_en_out  out  1  committed integrator enable
- spi_en_out  out  1  committed SPI enable
- drain_req  out  1  request core to reach safe point
- cfg_update  out  1  one-cycle pulse, first cycle new outputs valid
- busy  out  1  state != IDLE
- timeout_err  out  1  high while in ERROR

## Operation
- One clock (spi_clk). Reset is synchronous and active-high (sync_reset).
- All outputs are registered. Reset drives every output to 0, state to IDLE, and clears the shadow and counters. Reset overrides any state; drain_req drops at the reset edge.
- "cand" is the 49-bit concatenation of the *_in ports. "applied" is the concatenation of the *_out ports. "shadow" is an internal 49-bit latch.
- IDLE: if in_stable && cand != applied, latch shadow <= cand, cnt <= 1, go to SETTLE.
- SETTLE: if !in_stable or cand != shadow, re-latch shadow <= cand and set cnt <= 1 (restart).
  - Otherwise the new count is cnt+1. When it equals SETTLE_CYCLES: go to APPLY if spi_en_out == 0, else go to DRAIN with drain_req <= 1 and dcnt <= 0.
- DRAIN: inputs are ignored and shadow is frozen.
  - drain_ack sampled high -> APPLY.
  - Otherwise dcnt++. When dcnt reaches DRAIN_TIMEOUT -> ERROR, with drain_req <= 0, spi_en_out <= 0, timeout_err <= 1. Other outputs are held.
- APPLY (1 cycle): outputs <= shadow, cfg_update <= 1, drain_req <= 0.
  - If reached via DRAIN -> RELEASE.
  - Otherwise -> IDLE.
- RELEASE: wait for drain_ack == 0, then go to IDLE. No timeout.
- ERROR: hold until err_clear is sampled high, then go to IDLE with timeout_err <= 0. err_clear is ignored in all other states.
- After any return to IDLE, a residual cand != applied retriggers the sequence normally. This includes a change that arrived during DRAIN, or after ERROR forced spi_en_out to 0.
- Enabling from disabled (spi_en_out == 0) never drains. Disabling, or any change while enabled, always drains.
- drain_ack outside DRAIN/RELEASE is ignored.

## Timing
- Edge 0: IDLE samples a valid mismatch. SETTLE transitions at edge SETTLE_CYCLES-1.
- No-drain path: APPLY at edge SETTLE_CYCLES. New outputs and cfg_update are visible in the cycle after edge SETTLE_CYCLES.
- Drain path: drain_req is high from edge SETTLE_CYCLES-1.
  - If drain_ack is first sampled high at edge D, APPLY occurs at edge D+1. Outputs, cfg_update=1 and drain_req=0 are visible after edge D+1.
  - drain_ack already high at DRAIN entry: D = SETTLE_CYCLES, with no extra wait.
- Timeout: ERROR entered at the DRAIN_TIMEOUT-th DRAIN edge without ack. timeout_err and spi_en_out=0 are visible the following cycle.
- cfg_update is exactly 1 cycle wide. Back-to-back commits are separated by at least SETTLE_CYCLES+1 cycles.
- busy rises the cycle after edge 0. It falls the cycle after the edge that returns to IDLE.
- drain_ack and drain_ack rising in the same cycle as a timeout: ack wins (APPLY).

## Test plan
- Reset, then integ_window_in=1000 with in_stable=1 and spi_en_out=0 -> after 4 edges integ_window_out=1000, cfg_update high for 1 cycle, drain_req never high.
- spi_en_out=1, change integ_thresh_avg_in to 0x1234 -> drain_req high. Assert drain_ack 5 cycles later -> outputs update the cycle after ack; drain_req low; RELEASE holds until ack drops; busy stays high until then.
- Toggle integ_en_in every 2 cycles for 20 cycles (SETTLE_CYCLES=4) -> no commit. Hold steady -> commit occurs 4 edges after the last change.
- Drop in_stable for 1 cycle mid-SETTLE -> count restarts, and the commit is delayed by the corresponding cycles.
- DRAIN_TIMEOUT=8, never ack -> ERROR after 8 cycles; timeout_err=1, spi_en_out=0. err_clear -> IDLE. With spi_en_in=1 still set, a no-drain re-enable commit follows.
- Assert sync_reset while in DRAIN -> next cycle all outputs are 0, drain_req=0, busy=0. A later drain_ack has no effect.

Source files
------------

// File: rtl/shim_spi_cfg_apply_ctrl.sv
// Shim config apply sequencer: settles synchronized config, drains the SPI
// core when needed, then commits the whole set atomically.
// Ports:
//   spi_clk, sync_reset               - clock, sync active-high reset
//   *_in, in_stable                   - candidate config and stability flag
//   drain_ack, err_clear              - core safe-point ack, error clear
//   *_out                             - committed config
//   drain_req, cfg_update             - drain request, commit pulse
//   busy, timeout_err                 - sequencer status
module shim_spi_cfg_apply_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        spi_clk,
  input  logic        sync_reset,
  input  logic [14:0] integ_thresh_avg_in,
  input  logic [31:0] integ_window_in,
  input  logic        integ_en_in,
  input  logic        spi_en_in,
  input  logic        in_stable,
  input  logic        drain_ack,
  input  logic        err_clear,
  output logic [14:0] integ_thresh_avg_out,
  output logic [31:0] integ_window_out,
  output logic        integ_en_out,
  output logic        spi_en_out,
  output logic        drain_req,
  output logic        cfg_update,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DRAIN,
    S_APPLY,
    S_RELEASE,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [48:0]   r_shadow;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dcnt;
  logic          r_via_drain;

  logic [48:0]   w_cand;
  logic [48:0]   w_applied;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_dcnt_nxt;

  assign w_cand = {integ_thresh_avg_in, integ_window_in,
                   integ_en_in, spi_en_in};
  assign w_applied = {integ_thresh_avg_out, integ_window_out,
                      integ_en_out, spi_en_out};
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_dcnt_nxt = r_dcnt + 1'b1;

  always_ff @(posedge spi_clk) begin
    if (sync_reset) begin
      r_state              <= S_IDLE;
      r_shadow             <= '0;
      r_cnt                <= '0;
      r_dcnt               <= '0;
      r_via_drain          <= 1'b0;
      integ_thresh_avg_out <= '0;
      integ_window_out     <= '0;
      integ_en_out         <= 1'b0;
      spi_en_out           <= 1'b0;
      drain_req            <= 1'b0;
      cfg_update           <= 1'b0;
      busy                 <= 1'b0;
      timeout_err          <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_stable && (w_cand != w_applied)) begin
            r_shadow <= w_cand;
            r_cnt    <= CW'(1);
            r_state  <= S_SETTLE;
            busy     <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (!in_stable || (w_cand != r_shadow)) begin
            r_shadow <= w_cand;
            r_cnt    <= CW'(1);
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == SETTLE_MAX) begin
              // Enabling from disabled is safe without a drain.
              if (!spi_en_out) begin
                r_via_drain <= 1'b0;
                r_state     <= S_APPLY;
              end else begin
                r_via_drain <= 1'b1;
                drain_req   <= 1'b1;
                r_dcnt      <= '0;
                r_state     <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          // Ack wins over a timeout on the same edge.
          if (drain_ack) begin
            r_state <= S_APPLY;
          end else begin
            r_dcnt <= w_dcnt_nxt;
            if (w_dcnt_nxt == DRAIN_MAX) begin
              drain_req   <= 1'b0;
              spi_en_out  <= 1'b0;
              timeout_err <= 1'b1;
              r_state     <= S_ERROR;
            end
          end
        end
        S_APPLY: begin
          {integ_thresh_avg_out, integ_window_out,
           integ_en_out, spi_en_out} <= r_shadow;
          cfg_update <= 1'b1;
          drain_req  <= 1'b0;
          if (r_via_drain) begin
            r_state <= S_RELEASE;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!drain_ack) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_ERROR: begin
          if (err_clear) begin
            timeout_err <= 1'b0;
            r_state     <= S_IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
